// File: rtl/delay_sum_beamformer_if.sv
// rtl/delay_sum_beamformer_if.sv - sampler-side inputs and beam outputs of the delay-and-sum beamformer
interface delay_sum_beamformer_if #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]   ch0;
    logic [DW-1:0]   ch1;
    logic [DW-1:0]   ch2;
    logic [DW-1:0]   ch3;
    logic            newSample;
    logic [AW-1:0]   delay0;
    logic [AW-1:0]   delay1;
    logic [AW-1:0]   delay2;
    logic [AW-1:0]   delay3;
    logic [DW+1:0]   beam_out;
    logic            beam_valid;
    logic            overrun;

    modport master (
        output ch0, ch1, ch2, ch3, newSample, delay0, delay1, delay2, delay3,
        input  beam_out, beam_valid, overrun
    );

    modport slave (
        input  ch0, ch1, ch2, ch3, newSample, delay0, delay1, delay2, delay3,
        output beam_out, beam_valid, overrun
    );
endinterface

// File: rtl/delay_sum_beamformer.sv
// rtl/delay_sum_beamformer.sv - four-channel delay-and-sum beamformer with circular delay lines
// Define BEAMFORMER_AVG_EN to output the truncated mean instead of the full sum.
module delay_sum_beamformer #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                  clk,
    input  logic                  n_reset,
    delay_sum_beamformer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = DW + 2;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      k;
    logic            s1, s2, s3;
    logic            cap_evt;
    logic            load, mem_we, rd_en, acc_add, done;
    logic [DW-1:0]   hold_ch  [4];
    logic [AW-1:0]   hold_dly [4];
    logic [DW-1:0]   mem      [4][DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic [SW-1:0]   acc;
    logic [SW-1:0]   beam_sum;
    logic [SW-1:0]   beam_q;
    logic            valid_q;
    logic            overrun_q;

    // s1..s3 reset high so a newSample already high at reset release is not an edge
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= bus.newSample;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign cap_evt = s2 & ~s3;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cap_evt)     state_nxt = WRITE;
            WRITE:   if (k == 3'd3)   state_nxt = READ;
            READ:    if (k == 3'd4)   state_nxt = DONE;
            DONE:                     state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        mem_we  = 1'b0;
        rd_en   = 1'b0;
        acc_add = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE:    load    = cap_evt;
            WRITE:   mem_we  = 1'b1;
            READ: begin
                rd_en   = (k != 3'd4);
                acc_add = (k != 3'd0);
            end
            DONE:    done    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)                k <= 3'd0;
        else if (state != state_nxt) k <= 3'd0;
        else if (state == WRITE || state == READ) k <= k + 3'd1;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int c = 0; c < 4; c++) begin
                hold_ch[c]  <= '0;
                hold_dly[c] <= '0;
            end
        end else if (load) begin
            hold_ch[0]  <= bus.ch0;
            hold_ch[1]  <= bus.ch1;
            hold_ch[2]  <= bus.ch2;
            hold_ch[3]  <= bus.ch3;
            hold_dly[0] <= bus.delay0;
            hold_dly[1] <= bus.delay1;
            hold_dly[2] <= bus.delay2;
            hold_dly[3] <= bus.delay3;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < DEPTH; i++)
                    mem[c][i] <= '0;
        end else if (mem_we) begin
            mem[k[1:0]][wr_ptr] <= hold_ch[k[1:0]];
        end
    end

    // subtraction wraps modulo DEPTH because the pointer width is log2(DEPTH)
    assign rd_addr = wr_ptr - hold_dly[k[1:0]];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)   rd_data <= '0;
        else if (rd_en) rd_data <= mem[k[1:0]][rd_addr];
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)     acc <= '0;
        else if (load)    acc <= '0;
        else if (acc_add) acc <= acc + {2'b00, rd_data};
    end

`ifdef BEAMFORMER_AVG_EN
    assign beam_sum = {2'b00, acc[SW-1:2]};
`else
    assign beam_sum = acc;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            beam_q    <= '0;
            valid_q   <= 1'b0;
            wr_ptr    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= done;
            if (done) begin
                beam_q <= beam_sum;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (cap_evt && state != IDLE) overrun_q <= 1'b1;
        end
    end

    assign bus.beam_out   = beam_q;
    assign bus.beam_valid = valid_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_delay_sum_beamformer.sv
// tb/tb_delay_sum_beamformer.sv - scoreboard bench for delay_sum_beamformer
module tb_delay_sum_beamformer;
    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    delay_sum_beamformer_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

    delay_sum_beamformer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int hist [4][256];
    int ev_n  = 0;
    logic [DW+1:0] exp_q [$];

    task automatic clear_model();
        ev_n = 0;
        exp_q.delete();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 256; i++) hist[c][i] = 0;
    endtask

    task automatic drive_inputs(input int c0, c1, c2, c3, d0, d1, d2, d3);
        bus.ch0 = DW'(c0); bus.ch1 = DW'(c1); bus.ch2 = DW'(c2); bus.ch3 = DW'(c3);
        bus.delay0 = 4'(d0); bus.delay1 = 4'(d1); bus.delay2 = 4'(d2); bus.delay3 = 4'(d3);
    endtask

    // Raise newSample and push the expected beam computed from the event history
    task automatic send_event(input int c0, c1, c2, c3, d0, d1, d2, d3);
        int c [4];
        int d [4];
        int sum;
        c = '{c0, c1, c2, c3};
        d = '{d0, d1, d2, d3};
        @(negedge clk);
        drive_inputs(c0, c1, c2, c3, d0, d1, d2, d3);
        bus.newSample = 1'b1;
        for (int i = 0; i < 4; i++) hist[i][ev_n] = c[i];
        sum = 0;
        for (int i = 0; i < 4; i++)
            if (ev_n - d[i] >= 0) sum += hist[i][ev_n - d[i]];
        ev_n++;
`ifdef BEAMFORMER_AVG_EN
        exp_q.push_back((DW+2)'(sum / 4));
`else
        exp_q.push_back((DW+2)'(sum));
`endif
    endtask

    // Waits a fixed 20-cycle window; scrambles inputs mid-operation, which must not matter
    task automatic get_beam(output bit got, output int lat, output logic [DW+1:0] val, output int width);
        got = 1'b0; lat = 0; val = '0; width = 0;
        for (int cnt = 1; cnt <= 20; cnt++) begin
            @(negedge clk);
            if (cnt == 3) bus.newSample = 1'b0;
            if (cnt == 5) drive_inputs($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                                       $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 15),
                                       $urandom_range(0, 15), $urandom_range(0, 15));
            if (bus.beam_valid) begin
                if (!got) begin
                    got = 1'b1; lat = cnt; val = bus.beam_out;
                end
                width++;
            end
        end
    endtask

    task automatic apply_reset(input logic ns);
        @(negedge clk);
        n_reset = 1'b0;
        bus.newSample = ns;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        clear_model();
    endtask

    task automatic pop_exp(output logic [DW+1:0] e, output bit ok);
        ok = exp_q.size() > 0;
        e = ok ? exp_q.pop_front() : '0;
    endtask

    task automatic test_reset();
        int nv;
        drive_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        apply_reset(1'b1);
        @(negedge clk);
        total++; if (bus.beam_out !== 10'd0) begin bad++; $display("FAIL reset_beam_out got=%0d want=0", bus.beam_out); end
        total++; if (bus.beam_valid !== 1'b0) begin bad++; $display("FAIL reset_beam_valid got=%b want=0", bus.beam_valid); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.overrun); end
        nv = 0;
        repeat (100) begin @(negedge clk); if (bus.beam_valid) nv++; end
        total++; if (nv !== 0) begin bad++; $display("FAIL reset_no_spurious got=%0d strobes want=0", nv); end
        bus.newSample = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_zero_delay();
        bit got, ok; int lat, width; logic [DW+1:0] val, e;
        send_event(10, 20, 30, 40, 0, 0, 0, 0);
        get_beam(got, lat, val, width);
        pop_exp(e, ok);
        total++; if (!(got && ok)) begin bad++; $display("FAIL zero_got got=%b want=1", got); end
        total++; if (lat !== 13) begin bad++; $display("FAIL zero_latency got=%0d want=13", lat); end
        total++; if (width !== 1) begin bad++; $display("FAIL zero_strobe_width got=%0d want=1", width); end
        total++; if (val !== e) begin bad++; $display("FAIL zero_value got=%0d want=%0d", val, e); end
        repeat (5) @(negedge clk);
        total++; if (bus.beam_out !== e) begin bad++; $display("FAIL zero_hold got=%0d want=%0d", bus.beam_out, e); end
    endtask

    task automatic test_steering();
        bit got, ok; int lat, width; logic [DW+1:0] val, e;
        apply_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            send_event(0, 5 + i, 0, 0, 0, 2, 0, 0);
            get_beam(got, lat, val, width);
            pop_exp(e, ok);
            total++; if (!(got && ok)) begin bad++; $display("FAIL steer_got ev=%0d got=%b want=1", i, got); end
            total++; if (val !== e) begin bad++; $display("FAIL steer_value ev=%0d got=%0d want=%0d", i, val, e); end
        end
    endtask

    task automatic test_wrap_full_scale();
        bit got, ok; int lat, width; logic [DW+1:0] val, e;
        apply_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            send_event(255, 255, 255, 255, 15, 15, 15, 15);
            get_beam(got, lat, val, width);
            pop_exp(e, ok);
            total++; if (!(got && ok)) begin bad++; $display("FAIL wrap_got ev=%0d got=%b want=1", i, got); end
            total++; if (val !== e) begin bad++; $display("FAIL wrap_value ev=%0d got=%0d want=%0d", i, val, e); end
        end
    endtask

    task automatic test_overrun();
        bit ok; int nv; logic [DW+1:0] val, e;
        apply_reset(1'b0);
        send_event(1, 2, 3, 4, 0, 0, 0, 0);
        nv = 0; val = '0;
        for (int cnt = 1; cnt <= 40; cnt++) begin
            @(negedge clk);
            if (cnt == 3) bus.newSample = 1'b0;
            if (cnt == 6) begin drive_inputs(50, 50, 50, 50, 0, 0, 0, 0); bus.newSample = 1'b1; end
            if (cnt == 9) bus.newSample = 1'b0;
            if (bus.beam_valid) begin nv++; val = bus.beam_out; end
        end
        pop_exp(e, ok);
        total++; if (nv !== 1) begin bad++; $display("FAIL overrun_strobes got=%0d want=1", nv); end
        total++; if (!ok || val !== e) begin bad++; $display("FAIL overrun_value got=%0d want=%0d", val, e); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", bus.overrun); end
        repeat (50) @(negedge clk);
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", bus.overrun); end
    endtask

    task automatic test_reset_mid();
        bit got, ok; int nv, lat, width; logic [DW+1:0] val, e;
        apply_reset(1'b0);
        @(negedge clk);
        drive_inputs(9, 9, 9, 9, 0, 0, 0, 0);
        bus.newSample = 1'b1;
        nv = 0;
        for (int cnt = 1; cnt <= 30; cnt++) begin
            @(negedge clk);
            if (cnt == 9)  n_reset = 1'b0;
            if (cnt == 10) n_reset = 1'b1;
            if (cnt == 12) bus.newSample = 1'b0;
            if (bus.beam_valid) nv++;
        end
        clear_model();
        total++; if (nv !== 0) begin bad++; $display("FAIL midreset_strobes got=%0d want=0", nv); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL midreset_overrun got=%b want=0", bus.overrun); end
        send_event(1, 1, 1, 1, 0, 0, 0, 0);
        get_beam(got, lat, val, width);
        pop_exp(e, ok);
        total++; if (!(got && ok)) begin bad++; $display("FAIL midreset_got got=%b want=1", got); end
        total++; if (val !== e) begin bad++; $display("FAIL midreset_value got=%0d want=%0d", val, e); end
    endtask

    task automatic test_random_stream();
        bit got, ok; int lat, width; logic [DW+1:0] val, e;
        for (int i = 0; i < 24; i++) begin
            send_event($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            get_beam(got, lat, val, width);
            pop_exp(e, ok);
            total++; if (!(got && ok) || val !== e) begin bad++; $display("FAIL random_value ev=%0d got=%0d want=%0d", i, val, e); end
        end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL random_overrun got=%b want=0", bus.overrun); end
    endtask

    initial begin
        bus.newSample = 1'b1;
        drive_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        clear_model();
        test_reset();
        test_zero_delay();
        test_steering();
        test_wrap_full_scale();
        test_overrun();
        test_reset_mid();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
